frog_mover: RTL and testbench

Game-state stage directly downstream of the four key-input edge detectors: consumes their single-cycle direction pulses and maintains the frog's grid position, win/death sequencing, score and lives. Its outputs feed the LED-matrix renderer and the collision checker; the collision checker's `hit` feeds back into this block.

---
 rtl/frog_mover_if.sv | 33 +++
 rtl/frog_mover.sv | 123 ++++++++++++
 tb/tb_frog_mover.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frog_mover_if.sv
// frog_mover_if: groups the frog game-state stage's move/hit inputs and its
// position, score and status outputs. The master drives the pulses and hit;
// the slave (frog_mover) drives position and status.
interface frog_mover_if #(
    parameter int unsigned COLS = 16,
    parameter int unsigned ROWS = 16
);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);

    logic          up;
    logic          down;
    logic          left;
    logic          right;
    logic          hit;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    score;
    logic [2:0]    lives;
    logic          win;
    logic          dying;
    logic          game_over;

    modport master (
        output up, down, left, right, hit,
        input  x, y, score, lives, win, dying, game_over
    );

    modport slave (
        input  up, down, left, right, hit,
        output x, y, score, lives, win, dying, game_over
    );
endinterface

// File: rtl/frog_mover.sv
// frog_mover: frog position, win/death sequencing, score and lives.
// Optional feature macro FROG_LIVES_EN: when defined, lives decrement on each
// hit and the game ends in OVER once they run out; when undefined, lives stay
// at LIVES, game_over is tied low and every death ends in a respawn.
module frog_mover #(
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned START_X      = 7,
    parameter int unsigned START_Y      = 15,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned DEATH_CYCLES = 4
) (
    input logic         clock,
    input logic         reset,
    frog_mover_if.slave io_bus
);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned CW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;

    localparam logic [XW-1:0] XStart = XW'(START_X);
    localparam logic [YW-1:0] YStart = YW'(START_Y);
    localparam logic [XW-1:0] XMax   = XW'(COLS - 1);
    localparam logic [YW-1:0] YMax   = YW'(ROWS - 1);
    localparam logic [CW-1:0] CntTop = CW'(DEATH_CYCLES - 1);

    typedef enum logic [1:0] {StPlay, StWin, StDead, StOver} state_e;

    state_e        r_state, w_state_d;
    logic [XW-1:0] r_x, w_x_d;
    logic [YW-1:0] r_y, w_y_d;
    logic [7:0]    r_score, w_score_d;
    logic [2:0]    r_lives, w_lives_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [3:0]    w_pulses;

    assign w_pulses = {io_bus.up, io_bus.down, io_bus.left, io_bus.right};

    // State register; reset returns to the respawn position immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StPlay;
            r_x     <= XStart;
            r_y     <= YStart;
            r_score <= 8'd0;
            r_lives <= 3'(LIVES);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_score <= w_score_d;
            r_lives <= w_lives_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state: moves with edge clamping, hit priority, win and death exits.
    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_score_d = r_score;
        w_lives_d = r_lives;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StPlay: begin
                if (io_bus.hit) begin
                    w_state_d = StDead;
                    w_cnt_d   = CntTop;
`ifdef FROG_LIVES_EN
                    w_lives_d = r_lives - 3'd1;
`endif
                end else if ($onehot(w_pulses)) begin
                    unique case (w_pulses)
                        4'b1000: begin
                            if (r_y != '0) w_y_d = r_y - YW'(1);
                            if (r_y == YW'(1)) w_state_d = StWin;
                        end
                        4'b0100: if (r_y != YMax) w_y_d = r_y + YW'(1);
                        4'b0010: if (r_x != '0) w_x_d = r_x - XW'(1);
                        default: if (r_x != XMax) w_x_d = r_x + XW'(1);
                    endcase
                end
            end
            StWin: begin
                w_state_d = StPlay;
                w_x_d     = XStart;
                w_y_d     = YStart;
                if (r_score != 8'hFF) w_score_d = r_score + 8'd1;
            end
            StDead: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CW'(1);
`ifdef FROG_LIVES_EN
                end else if (r_lives == 3'd0) begin
                    // Position stays frozen at the death cell.
                    w_state_d = StOver;
`endif
                end else begin
                    w_state_d = StPlay;
                    w_x_d     = XStart;
                    w_y_d     = YStart;
                end
            end
            default: w_state_d = StOver;
        endcase
    end

    assign io_bus.x     = r_x;
    assign io_bus.y     = r_y;
    assign io_bus.score = r_score;
    assign io_bus.win   = (r_state == StWin);
    assign io_bus.dying = (r_state == StDead);
`ifdef FROG_LIVES_EN
    assign io_bus.lives     = r_lives;
    assign io_bus.game_over = (r_state == StOver);
`else
    assign io_bus.lives     = 3'(LIVES);
    assign io_bus.game_over = 1'b0;
`endif

endmodule

// File: tb/tb_frog_mover.sv
// tb_frog_mover: directed bench for frog_mover with hand-computed expectations.
// Expectations follow FROG_LIVES_EN so the bench fits either build.
module tb_frog_mover;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef FROG_LIVES_EN
    localparam bit LivesEn = 1'b1;
`else
    localparam bit LivesEn = 1'b0;
`endif

    frog_mover_if #(.COLS(16), .ROWS(16)) bus ();

    frog_mover dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one rising edge; returns at the following falling edge.
    task automatic drive(input logic u, input logic d, input logic l, input logic r,
                         input logic h);
        bus.up = u; bus.down = d; bus.left = l; bus.right = r; bus.hit = h;
        @(negedge clock);
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.hit = 0;
    endtask

    // Move left once, take a hit and run the whole freeze with moves attempted.
    task automatic hit_cycle(input int unsigned exp_lives, input bit exp_over);
        drive(0, 0, 1, 0, 0);
        check_eq("pre_hit_x", bus.x, 6);
        drive(1, 0, 0, 0, 1);
        check_eq("hit_dying", bus.dying, 1);
        check_eq("hit_lives", bus.lives, exp_lives);
        check_eq("hit_nomove_y", bus.y, 15);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 1);
            check_eq("freeze_dying", bus.dying, 1);
            check_eq("freeze_x", bus.x, 6);
        end
        drive(0, 0, 0, 0, 0);
        check_eq("exit_dying", bus.dying, 0);
        check_eq("exit_over", bus.game_over, exp_over);
        check_eq("exit_x", bus.x, exp_over ? 6 : 7);
        check_eq("exit_y", bus.y, 15);
    endtask

    initial begin
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.hit = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_x", bus.x, 7);
        check_eq("rst_y", bus.y, 15);
        check_eq("rst_score", bus.score, 0);
        check_eq("rst_lives", bus.lives, 3);
        check_eq("rst_flags", {bus.win, bus.dying, bus.game_over}, 0);

        // Ten lefts: 6,5,...,0 then clamped at 0.
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 1, 0, 0);
            check_eq("left_x", bus.x, (i < 7) ? 7 - i : 0);
            check_eq("left_y", bus.y, 15);
        end
        drive(0, 0, 0, 1, 0);
        check_eq("right_x", bus.x, 1);
        drive(0, 1, 0, 0, 0);
        check_eq("down_clamp_y", bus.y, 15);

        // Climb to the goal.
        for (int i = 1; i <= 14; i++) begin
            drive(1, 0, 0, 0, 0);
            check_eq("up_y", bus.y, 15 - i);
        end
        check_eq("pre_win", bus.win, 0);
        drive(1, 0, 0, 0, 0);
        check_eq("win_y", bus.y, 0);
        check_eq("win_flag", bus.win, 1);
        check_eq("win_score_hold", bus.score, 0);
        drive(0, 0, 1, 0, 1);  // ignored during WIN
        check_eq("respawn_x", bus.x, 7);
        check_eq("respawn_y", bus.y, 15);
        check_eq("respawn_score", bus.score, 1);
        check_eq("respawn_win", bus.win, 0);
        check_eq("respawn_dying", bus.dying, 0);

        drive(1, 0, 1, 0, 0);
        check_eq("dual_x", bus.x, 7);
        check_eq("dual_y", bus.y, 15);

        hit_cycle(LivesEn ? 2 : 3, 0);
        hit_cycle(LivesEn ? 1 : 3, 0);
        hit_cycle(LivesEn ? 0 : 3, LivesEn);
        if (!LivesEn) begin
            hit_cycle(3, 0);
            hit_cycle(3, 0);
        end

        drive(1, 0, 0, 0, 0);
        check_eq("post_up_y", bus.y, LivesEn ? 15 : 14);
        check_eq("post_dying", bus.dying, 0);

        // Asynchronous reset away from any clock edge.
        #1 reset = 1'b0;
        #1;
        check_eq("arst_lives", bus.lives, 3);
        check_eq("arst_over", bus.game_over, 0);
        check_eq("arst_x", bus.x, 7);
        check_eq("arst_y", bus.y, 15);
        check_eq("arst_score", bus.score, 0);
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 0, 1, 0);
        check_eq("play_after_rst_x", bus.x, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
